// File: rtl/spi_ram_master.sv
// spi_ram_master: serialises host commands as SPI frames and captures read-data replies from MISO
module spi_ram_master #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [ADDR_SIZE-1:0] cmd_data,
  output logic [ADDR_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 cmd_err,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);
  localparam int CW = 16;
  localparam int FW = ADDR_SIZE + 2;
  typedef enum logic [2:0] {IDLE, START, SHIFT_OUT, WAIT_RESP, SHIFT_IN, GAP} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          sh_q, sh_d;
  logic [1:0]             type_q, type_d;
  logic                   pend_q, pend_d;
  logic [ADDR_SIZE-1:0]   rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   err_q, err_d;
  logic                   hs, illegal;
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = state_q != IDLE;
  assign SS_n      = (state_q == IDLE) || (state_q == GAP);
  assign MOSI      = (state_q == SHIFT_OUT) ? sh_q[FW-1] : 1'b0;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign cmd_err   = err_q;
  assign hs        = cmd_valid && cmd_ready;
  // a read-addr may not follow an unconsumed read-addr; a read-data needs one pending
  assign illegal   = (cmd_type == 2'b10 && pend_q) || (cmd_type == 2'b11 && !pend_q);
  // state, shift and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      type_q     <= 2'b00;
      pend_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      type_q     <= type_d;
      pend_q     <= pend_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end
  // frame sequencing: one counter is reused for bits, latency and gap timing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    sh_d       = sh_q;
    type_d     = type_q;
    pend_d     = pend_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hs && illegal) err_d = 1'b1;
        if (hs && !illegal) begin
          state_d = START;
          type_d  = cmd_type;
          sh_d    = {cmd_type, (cmd_type == 2'b11) ? {ADDR_SIZE{1'b0}} : cmd_data};
        end
      end
      START: begin
        state_d = SHIFT_OUT;
        cnt_d   = '0;
      end
      SHIFT_OUT: begin
        sh_d = sh_q << 1;
        if (cnt_q == CW'(FW - 1)) begin
          cnt_d   = '0;
          state_d = (type_q != 2'b11) ? GAP : (RD_LATENCY == 0) ? SHIFT_IN : WAIT_RESP;
          pend_d  = (type_q == 2'b10) ? 1'b1 : pend_q;
        end
      end
      WAIT_RESP: begin
        if (cnt_q == CW'(RD_LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        sh_d = {sh_q[FW-2:0], MISO};
        if (cnt_q == CW'(ADDR_SIZE - 1)) begin
          cnt_d      = '0;
          state_d    = GAP;
          rd_data_d  = {sh_q[ADDR_SIZE-2:0], MISO};
          rd_valid_d = 1'b1;
          pend_d     = 1'b0;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- SPI master that drives the single-port-RAM SPI slave in this codebase.
- Accepts command requests from a host-side valid/ready interface and serialises each one as a frame on SS_n/MOSI, MSB first.
- For read-data commands it captures the returned word from MISO and presents it to the host.
- Sits between the test host/CPU logic and the slave+RAM wrapper; SPI bit rate equals clk, shared with the slave.

Parameters:
- ADDR_SIZE, 8, payload/address/data width; frame length is ADDR_SIZE+2 bits.
- RD_LATENCY, 2, clk cycles between the last MOSI bit of a read-data frame and the first MISO bit sampled.
- GAP_CYCLES, 1, minimum cycles SS_n is held high between frames (range 1..15).

Ports:
- clk  input  1  system clock, also the SPI bit clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  host command request.
- cmd_ready  output  1  master can accept a command.
- cmd_type  input  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- cmd_data  input  ADDR_SIZE  payload (address or write data; ignored for 11, sent as zeros).
- rd_data  output  ADDR_SIZE  word captured from MISO.
- rd_valid  output  1  one-cycle pulse, rd_data valid.
- cmd_err  output  1  one-cycle pulse, illegal read sequencing rejected.
- busy  output  1  frame in progress (SS_n low or in gap).
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave.

Behaviour:
- Reset (rst=1 at posedge clk):
  - Outputs: SS_n=1, MOSI=0, cmd_ready=0 during reset then 1 in IDLE, rd_data=0, rd_valid=0, cmd_err=0, busy=0.
  - Internal state: state=IDLE, rd_addr_pending=0.
  - Reset mid-frame aborts immediately: SS_n=1 on the next cycle, no rd_valid.
- States: IDLE, START, SHIFT_OUT, WAIT_RESP, SHIFT_IN, GAP.
- IDLE:
  - cmd_ready=1.
  - Handshake occurs on a cycle with cmd_valid & cmd_ready. The master latches shift register {cmd_type, cmd_data} (payload forced to 0 for 11).
  - Sequencing check: type 10 with rd_addr_pending=1, or type 11 with rd_addr_pending=0, is illegal. The master pulses cmd_err the next cycle, sends no frame and stays in IDLE.
  - Legal command goes to START.
- START: SS_n=0, MOSI=0, one cycle; goes to SHIFT_OUT. cmd_ready=0 from here until return to IDLE.
- SHIFT_OUT:
  - SS_n=0; MOSI = shift MSB; shift left each cycle.
  - Lasts exactly ADDR_SIZE+2 cycles, counted by a bit counter 0..ADDR_SIZE+1.
  - After the last bit: type 11 goes to WAIT_RESP; other types go to GAP.
- WAIT_RESP: SS_n=0, MOSI=0 for RD_LATENCY cycles, then SHIFT_IN. RD_LATENCY=0 goes directly to SHIFT_IN.
- SHIFT_IN:
  - SS_n=0, MOSI=0; samples MISO each cycle into rd_data MSB first, ADDR_SIZE samples.
  - After the last sample: rd_valid=1 for exactly one cycle with the complete word; go to GAP.
- GAP: SS_n=1, MOSI=0, busy=1 for GAP_CYCLES cycles, then IDLE.
- rd_addr_pending: set at the end of a type-10 frame, cleared at the end of a type-11 frame; unaffected by 00/01.
- busy=1 in every state except IDLE.
- rd_data holds its last value until the next completed read-data frame.
- cmd_valid asserted while busy is ignored; the host must hold it until it sees cmd_ready (no queueing).
- A write frame occupies 1+ADDR_SIZE+2+GAP_CYCLES cycles from acceptance to cmd_ready.
- A read-data frame adds RD_LATENCY+ADDR_SIZE cycles.

Test Plan:
- Reset then idle -> SS_n=1, MOSI=0, cmd_ready=1, busy=0, no pulses for 20 cycles.
- Write-addr 0x5A -> SS_n low 11 cycles (START + 10 bits); MOSI bits during SHIFT_OUT = 0,0,0,1,0,1,1,0,1,0; then SS_n high 1 cycle; cmd_ready back after 12 cycles.
- Write-data 0xC3 after write-addr 0x10 -> two frames with ≥1 gap cycle; MOSI payload 11000011 preceded by 01; slave model records RAM[0x10]=0xC3.
- Read-addr 0x10 then read-data, slave model returning 0xC3 on MISO with RD_LATENCY=2 -> read-data frame keeps SS_n low 1+10+2+8 cycles; rd_valid single pulse with rd_data=0xC3; rd_addr_pending cleared.
- Read-data with no prior read-addr, then two consecutive read-addr -> cmd_err pulse for the read-data, no SS_n activity; second read-addr yields a cmd_err pulse, no frame.
- rst asserted mid-SHIFT_IN of a read-data frame -> SS_n=1 on the next cycle, no rd_valid, rd_data=0, cmd_ready=1 after rst deasserts.
